// File: rtl/wb_port_arbiter_if.sv
// Write-port bus between the pipeline/multi-cycle producers and the register-file arbiter.
interface wb_port_arbiter_if #(
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          Pipe_RegWrite;
    logic [4:0]    Pipe_WriteReg;
    logic [31:0]   Pipe_WriteData;
    logic          Mc_Valid;
    logic [4:0]    Mc_WriteReg;
    logic [31:0]   Mc_WriteData;
    logic          Mc_Ready;
    logic          RF_RegWrite;
    logic [4:0]    RF_WriteReg;
    logic [31:0]   RF_WriteData;
    logic          Pipe_Stall;
    logic [CW-1:0] Pending_Count;

    modport master (
        output Pipe_RegWrite, Pipe_WriteReg, Pipe_WriteData,
        output Mc_Valid, Mc_WriteReg, Mc_WriteData,
        input  Mc_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData,
        input  Pipe_Stall, Pending_Count
    );

    modport slave (
        input  Pipe_RegWrite, Pipe_WriteReg, Pipe_WriteData,
        input  Mc_Valid, Mc_WriteReg, Mc_WriteData,
        output Mc_Ready, RF_RegWrite, RF_WriteReg, RF_WriteData,
        output Pipe_Stall, Pending_Count
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter; WB_STARVE_GUARD_EN selects the wait-counter starvation guard.
// Purpose: pipeline writeback wins the port, queued multi-cycle results fill idle cycles.
// Latency: pipeline 0 cycles; multi-cycle accept -> RF write at least 1 cycle.
// Backpressure: Mc_Ready drops when the queue is full; Pipe_Stall freezes the pipeline one cycle.
module wb_port_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 4
) (
    input logic              Clk,
    input logic              Rst_n,
    wb_port_arbiter_if.slave wb
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MAX_WAIT < 1) begin : g_bad_param
        $error("wb_port_arbiter: DEPTH must be a power of 2 >= 2 and MAX_WAIT >= 1");
    end

    typedef struct packed {
        logic [4:0]  wreg;
        logic [31:0] wdata;
    } wb_entry_t;

    wb_entry_t         mem [DEPTH];
    wb_entry_t         head;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              mc_ready;
    logic              enq_store;
    logic              pipe_owns;
    logic              pop;
    logic              stall_q;
    logic              stall_d;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign mc_ready  = Rst_n && !full;
    // Writes to r0 are handshaken away without occupying a slot.
    assign enq_store = wb.Mc_Valid && mc_ready && (wb.Mc_WriteReg != 5'd0);
    assign pipe_owns = !stall_q && wb.Pipe_RegWrite;
    assign pop       = !pipe_owns && !empty;
    assign head      = mem[rd_ptr];

    assign wb.Mc_Ready      = mc_ready;
    assign wb.Pipe_Stall    = stall_q;
    assign wb.Pending_Count = count;

    always_comb begin
        wb.RF_RegWrite  = 1'b0;
        wb.RF_WriteReg  = wb.Pipe_WriteReg;
        wb.RF_WriteData = wb.Pipe_WriteData;
        if (pipe_owns) begin
            wb.RF_RegWrite = Rst_n && (wb.Pipe_WriteReg != 5'd0);
        end else if (pop) begin
            wb.RF_RegWrite  = Rst_n;
            wb.RF_WriteReg  = head.wreg;
            wb.RF_WriteData = head.wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (enq_store) begin
            mem[wr_ptr] <= '{wreg: wb.Mc_WriteReg, wdata: wb.Mc_WriteData};
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq_store) wr_ptr <= wr_ptr + 1'b1;
            if (pop)       rd_ptr <= rd_ptr + 1'b1;
            case ({enq_store, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef WB_STARVE_GUARD_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt;
    logic          at_limit;

    assign at_limit = (wait_cnt == WW'(MAX_WAIT - 1));
    assign stall_d  = !empty && !pop && at_limit;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wait_cnt <= '0;
        end else if (pop || empty || at_limit) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    // A producer blocked by a full queue whose head lost the port forces a drain slot.
    assign stall_d = full && wb.Mc_Valid && !pop;
`endif

    // A stall cycle always pops (queue is non-empty), so stall_d cannot repeat back to back.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            stall_q <= 1'b0;
        end else begin
            stall_q <= stall_d;
        end
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus multi-cycle sequences.
module tb_wb_port_arbiter;
    logic Clk;
    logic Rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;

    wb_port_arbiter_if #(.DEPTH(2)) bus ();

    wb_port_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .wb    (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    typedef struct {
        logic        pw;
        logic [4:0]  preg;
        logic [31:0] pdat;
        logic        mv;
        logic [4:0]  mreg;
        logic [31:0] mdat;
        logic        ewe;
        logic [4:0]  ereg;
        logic [31:0] edat;
        logic        erdy;
        logic        estall;
        logic [1:0]  ecnt;
    } vec_t;

    vec_t vecs [11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic pw, input logic [4:0] preg, input logic [31:0] pdat,
                         input logic mv, input logic [4:0] mreg, input logic [31:0] mdat);
        bus.Pipe_RegWrite  = pw;
        bus.Pipe_WriteReg  = preg;
        bus.Pipe_WriteData = pdat;
        bus.Mc_Valid       = mv;
        bus.Mc_WriteReg    = mreg;
        bus.Mc_WriteData   = mdat;
    endtask

    task automatic check_out(input string tag, input logic ewe, input logic [4:0] ereg,
                             input logic [31:0] edat, input logic erdy, input logic estall,
                             input logic [1:0] ecnt);
        check({tag, ".we"},    {31'd0, bus.RF_RegWrite}, {31'd0, ewe});
        check({tag, ".rdy"},   {31'd0, bus.Mc_Ready},    {31'd0, erdy});
        check({tag, ".stall"}, {31'd0, bus.Pipe_Stall},  {31'd0, estall});
        check({tag, ".cnt"},   {30'd0, bus.Pending_Count}, {30'd0, ecnt});
        if (ewe) begin
            check({tag, ".reg"},  {27'd0, bus.RF_WriteReg}, {27'd0, ereg});
            check({tag, ".data"}, bus.RF_WriteData, edat);
        end
    endtask

    // One cycle: drive just after posedge, check at negedge, return just after next posedge.
    task automatic cyc(input string tag,
                       input logic pw, input logic [4:0] preg, input logic [31:0] pdat,
                       input logic mv, input logic [4:0] mreg, input logic [31:0] mdat,
                       input logic ewe, input logic [4:0] ereg, input logic [31:0] edat,
                       input logic erdy, input logic estall, input logic [1:0] ecnt);
        drive(pw, preg, pdat, mv, mreg, mdat);
        @(negedge Clk);
        check_out(tag, ewe, ereg, edat, erdy, estall, ecnt);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic [36:0] q[$];
        logic [36:0] hd;
        int          sent;
        int          written;
        int          cyc_n;
        logic        busy;
        logic        mv;
        logic        erdy;
        logic [1:0]  ecnt;

        //          pw preg  pdat          mv mreg  mdat          ewe ereg  edat          rdy stl cnt
        vecs[0]  = '{0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,        1, 0, 2'd0};
        vecs[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd5, 32'hDEADBEEF, 1, 0, 2'd1};
        vecs[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 2'd0};
        vecs[3]  = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h1234,     0, 5'd0, 32'h0,        1, 0, 2'd0};
        vecs[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 2'd0};
        vecs[5]  = '{1, 5'd0, 32'h5555,     0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 2'd0};
        vecs[6]  = '{1, 5'd12, 32'hA5A5A5A5, 0, 5'd0, 32'h0,       1, 5'd12, 32'hA5A5A5A5, 1, 0, 2'd0};
        vecs[7]  = '{1, 5'd3, 32'h33,       1, 5'd7, 32'h77,       1, 5'd3, 32'h33,       1, 0, 2'd0};
        vecs[8]  = '{1, 5'd3, 32'h34,       0, 5'd0, 32'h0,        1, 5'd3, 32'h34,       1, 0, 2'd1};
        vecs[9]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 5'd7, 32'h77,       1, 0, 2'd1};
        vecs[10] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        0, 5'd0, 32'h0,        1, 0, 2'd0};

        // Reset held with both producers active
        Rst_n = 1'b0;
        drive(1'b1, 5'd7, 32'h7777, 1'b1, 5'd5, 32'h5555);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        Rst_n = 1'b1;
        @(negedge Clk);
        check_out("release", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 2'd0);
        @(posedge Clk);
        #1;

        foreach (vecs[i]) begin
            cyc($sformatf("vec%0d", i), vecs[i].pw, vecs[i].preg, vecs[i].pdat,
                vecs[i].mv, vecs[i].mreg, vecs[i].mdat, vecs[i].ewe, vecs[i].ereg,
                vecs[i].edat, vecs[i].erdy, vecs[i].estall, vecs[i].ecnt);
        end

        // Pipe owns the port every cycle while R8/R9 wait in the queue
`ifdef WB_STARVE_GUARD_EN
        cyc("starve0",  1, 5'd3, 32'h300, 1, 5'd8, 32'h88, 1, 5'd3, 32'h300, 1, 0, 2'd0);
        cyc("starve1",  1, 5'd3, 32'h301, 1, 5'd9, 32'h99, 1, 5'd3, 32'h301, 1, 0, 2'd1);
        cyc("starve2",  1, 5'd3, 32'h302, 0, 5'd0, 32'h0,  1, 5'd3, 32'h302, 0, 0, 2'd2);
        cyc("starve3",  1, 5'd3, 32'h303, 0, 5'd0, 32'h0,  1, 5'd3, 32'h303, 0, 0, 2'd2);
        cyc("starve4",  1, 5'd3, 32'h304, 0, 5'd0, 32'h0,  1, 5'd3, 32'h304, 0, 0, 2'd2);
        cyc("starve5",  1, 5'd3, 32'h305, 0, 5'd0, 32'h0,  1, 5'd8, 32'h88,  0, 1, 2'd2);
        cyc("starve6",  1, 5'd3, 32'h305, 0, 5'd0, 32'h0,  1, 5'd3, 32'h305, 1, 0, 2'd1);
        cyc("starve7",  1, 5'd3, 32'h306, 0, 5'd0, 32'h0,  1, 5'd3, 32'h306, 1, 0, 2'd1);
        cyc("starve8",  1, 5'd3, 32'h307, 0, 5'd0, 32'h0,  1, 5'd3, 32'h307, 1, 0, 2'd1);
        cyc("starve9",  1, 5'd3, 32'h308, 0, 5'd0, 32'h0,  1, 5'd3, 32'h308, 1, 0, 2'd1);
        cyc("starve10", 1, 5'd3, 32'h309, 0, 5'd0, 32'h0,  1, 5'd9, 32'h99,  1, 1, 2'd1);
        cyc("starve11", 0, 5'd0, 32'h0,   0, 5'd0, 32'h0,  0, 5'd0, 32'h0,   1, 0, 2'd0);
`else
        cyc("starve0",  1, 5'd3, 32'h300, 1, 5'd8,  32'h88, 1, 5'd3,  32'h300, 1, 0, 2'd0);
        cyc("starve1",  1, 5'd3, 32'h301, 1, 5'd9,  32'h99, 1, 5'd3,  32'h301, 1, 0, 2'd1);
        cyc("starve2",  1, 5'd3, 32'h302, 1, 5'd10, 32'hAA, 1, 5'd3,  32'h302, 0, 0, 2'd2);
        cyc("starve3",  1, 5'd3, 32'h303, 1, 5'd10, 32'hAA, 1, 5'd8,  32'h88,  0, 1, 2'd2);
        cyc("starve4",  1, 5'd3, 32'h303, 1, 5'd10, 32'hAA, 1, 5'd3,  32'h303, 1, 0, 2'd1);
        cyc("starve5",  1, 5'd3, 32'h304, 0, 5'd0,  32'h0,  1, 5'd3,  32'h304, 0, 0, 2'd2);
        cyc("starve6",  0, 5'd0, 32'h0,   0, 5'd0,  32'h0,  1, 5'd9,  32'h99,  0, 0, 2'd2);
        cyc("starve7",  0, 5'd0, 32'h0,   0, 5'd0,  32'h0,  1, 5'd10, 32'hAA,  1, 0, 2'd1);
        cyc("starve8",  0, 5'd0, 32'h0,   0, 5'd0,  32'h0,  0, 5'd0,  32'h0,   1, 0, 2'd0);
`endif

        // Fill to full behind a busy pipe, then stream 10 results with the pipe idle
        sent    = 0;
        written = 0;
        cyc_n   = 0;
        while (written < 10 && cyc_n < 40) begin
            busy = (cyc_n < 2);
            mv   = (sent < 10);
            drive(busy, 5'd3, 32'h3000 + 32'(cyc_n), mv, 5'(16 + sent), 32'hC0DE0000 + 32'(sent));
            @(negedge Clk);
            erdy = (q.size() < 2);
            ecnt = 2'(q.size());
            if (busy) begin
                check_out($sformatf("wrap%0d", cyc_n), 1'b1, 5'd3, 32'h3000 + 32'(cyc_n),
                          erdy, 1'b0, ecnt);
            end else if (q.size() > 0) begin
                hd = q.pop_front();
                check_out($sformatf("wrap%0d", cyc_n), 1'b1, hd[36:32], hd[31:0],
                          erdy, 1'b0, ecnt);
                written++;
            end else begin
                check_out($sformatf("wrap%0d", cyc_n), 1'b0, 5'd0, 32'h0, erdy, 1'b0, ecnt);
            end
            if (mv && erdy) begin
                q.push_back({5'(16 + sent), 32'hC0DE0000 + 32'(sent)});
                sent++;
            end
            @(posedge Clk);
            #1;
            cyc_n++;
        end
        check("wrap_done", 32'(written), 32'd10);

        // Reset with two entries pending discards them
        cyc("rst0", 1, 5'd3, 32'h400, 1, 5'd20, 32'h2020, 1, 5'd3, 32'h400, 1, 0, 2'd0);
        cyc("rst1", 1, 5'd3, 32'h401, 1, 5'd21, 32'h2121, 1, 5'd3, 32'h401, 1, 0, 2'd1);
        drive(1'b1, 5'd3, 32'h402, 1'b0, 5'd0, 32'h0);
        @(negedge Clk);
        check_out("rst2", 1'b1, 5'd3, 32'h402, 1'b0, 1'b0, 2'd2);
        #1;
        Rst_n = 1'b0;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        check_out("rst_async", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 2'd0);
        @(posedge Clk);
        @(negedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc($sformatf("post_rst%0d", i), 0, 5'd0, 32'h0, 0, 5'd0, 32'h0,
                0, 5'd0, 32'h0, 1, 0, 2'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
